shared_ram_ctrl: RTL and testbench
==================================

// Module: shared_ram_ctrl
// PURPOSE
//  Single-port RAM controller directly downstream of the 3-way round-robin arbiter.
//  Consumes the arbitrated address, write-data and read/write_n bus and performs the access
//  after a programmable number of wait states. Returns read data, or write completion, to the
//  processor that currently owns the bus.
// PARAMETERS
//  ADDR_W    12        address width; memory depth = 2**ADDR_W words
//  DATA_W    8         data word width
//  WAIT_DEF  2         wait-state count loaded at reset (0..15)
// PORTS
//  clock        in   1       system clock; all logic on posedge
//  reset        in   1       synchronous, active-low reset
//  bus_valid    in   1       high while an arbiter grant drives addr/wdata/r_wb
//  r_wb         in   1       1 = read, 0 = write
//  addr         in   ADDR_W  word address
//  wdata        in   DATA_W  write data
//  wait_cfg_en  in   1       load wait_cfg into the wait-state register
//  wait_cfg     in   4       new wait-state count
//  busy         out  1       access in progress; new requests are ignored
//  rdata        out  DATA_W  registered read data; holds until the next read completes
//  rdata_valid  out  1       one-cycle pulse: rdata is valid
//  wr_done      out  1       one-cycle pulse: write committed
//  parity_err   out  1       one-cycle pulse with rdata_valid on a parity mismatch (see CONFIGURATION)
//  parity_inj   in   1       sampled with a write: store inverted parity (test hook)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, wait register=WAIT_DEF, wcnt=0, rdata=0.
//    busy, rdata_valid, wr_done and parity_err are 0. Memory contents are not cleared.
//  - FSM states: IDLE, WAIT, ACCESS, RESP. All outputs are registered or decoded from state.
//  - IDLE: if bus_valid=1, capture addr, wdata, r_wb and parity_inj into holding registers.
//    Next state is WAIT with wcnt=wait register if wait register>0, otherwise ACCESS.
//    The bus is not sampled again until the FSM returns to IDLE.
//  - WAIT: wcnt decrements each cycle. When wcnt==1, next state is ACCESS.
//  - ACCESS: on the closing edge, a write updates mem[addr_q]; a read loads rdata from mem[addr_q].
//    Next state is RESP.
//  - RESP: rdata_valid=1 for a read, wr_done=1 for a write (exactly one cycle). Next state is IDLE.
//  - busy=1 in WAIT, ACCESS and RESP; busy=0 in IDLE.
//  - Latency: bus_valid is sampled in cycle t; the response pulse appears in cycle t+2+W,
//    where W is the wait register value. One access completes per 3+W cycles.
//  - Changes on bus_valid or the bus while busy=1 (for example an arbiter re-grant) have no effect.
//  - wait_cfg_en is honoured in IDLE only and ignored while busy=1.
//    If wait_cfg_en and bus_valid are both high in IDLE, the request uses the OLD wait value;
//    the new value applies from the next request.
//  - W=0 means no WAIT state. W=15 is the maximum.
//  - Address wrap-around does not apply: addr is ADDR_W bits and maps 1:1 onto the memory.
//  - Reset mid-operation: return to IDLE. A write pending in WAIT or ACCESS is aborted and
//    the memory is NOT updated, even on the edge where reset is sampled. No response pulse is issued.
//  - Read after write to the same address returns the newly written data (the accesses are sequential).
// CONFIGURATION
//  - Macro RAM_PARITY_EN defined:
//    - A parity memory holds 1 bit per word, written with ^wdata_q, inverted if parity_inj_q=1.
//    - On a read, parity_err is registered at the ACCESS edge as (^rdata_new != stored bit)
//      and pulses in RESP together with rdata_valid.
//  - Macro not defined: no parity memory; parity_err tied to 0; parity_inj ignored.
//    The ports remain present in both builds.
// TESTING
//  1. Reset; write 0xA5 to 0x123, then read 0x123 -> wr_done at t+4; rdata=0xA5, rdata_valid at t+4.
//  2. wait_cfg=0 then 7; read -> rdata_valid at t+2 and t+9; busy high for exactly 2 and 9 cycles.
//  3. Toggle bus_valid/addr while busy -> only the first request is served; one pulse per request.
//  4. Write 0x3C to 0xFFF with W=5; pull reset low in the WAIT state; read 0xFFF -> old data, no wr_done.
//  5. wait_cfg_en and bus_valid in the same IDLE cycle with cfg 2->4 -> this request W=2, next W=4.
//  6. RAM_PARITY_EN: write 0x01 with parity_inj=1, then read -> parity_err=1 with rdata=0x01.
//     Without parity_inj -> parity_err=0.

Source files
------------

// File: rtl/shared_ram_ctrl.sv
// ---------------------------------------------------------------------------
// shared_ram_ctrl
//
// Purpose:
//   Single-port RAM controller that sits directly behind the 3-way
//   round-robin arbiter. It latches one arbitrated request, optionally
//   stalls for a programmable number of wait states, performs the read or
//   write, and then returns a one-cycle response pulse to the current bus
//   owner. Once a request has been latched, the bus is ignored until the
//   controller is idle again.
//
// Optional feature (macro RAM_PARITY_EN):
//   When defined, the controller keeps one parity bit per word. It flags a
//   mismatch on reads through parity_err. parity_inj stores inverted parity
//   for a write, which lets software exercise the error path.
//   When undefined, parity_err is tied low and parity_inj is ignored. Both
//   ports exist in either build.
//
// Ports:
//   clock        in   1       system clock, all logic on the rising edge
//   reset        in   1       synchronous, active-low reset
//   bus_valid    in   1       arbiter grant is driving addr/wdata/r_wb
//   r_wb         in   1       1 = read, 0 = write
//   addr         in   ADDR_W  word address
//   wdata        in   DATA_W  write data
//   wait_cfg_en  in   1       load wait_cfg into the wait-state register
//   wait_cfg     in   4       new wait-state count
//   parity_inj   in   1       store inverted parity with this write
//   busy         out  1       an access is in progress
//   rdata        out  DATA_W  last read data, held until the next read
//   rdata_valid  out  1       one-cycle pulse: rdata is fresh
//   wr_done      out  1       one-cycle pulse: write committed
//   parity_err   out  1       one-cycle pulse with rdata_valid on mismatch
// ---------------------------------------------------------------------------
module shared_ram_ctrl #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int WAIT_DEF = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bus_valid,
  input  logic              r_wb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wait_cfg_en,
  input  logic [3:0]        wait_cfg,
  input  logic              parity_inj,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              wr_done,
  output logic              parity_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        wait_q;
  logic [3:0]        wcnt_q, wcnt_d;

  // Request holding registers, loaded only when a request is accepted in IDLE
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              r_wb_q;
  logic              parity_inj_q;

  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;
  logic              rdata_valid_q;
  logic              wr_done_q;
  logic              parity_err_q;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] memRd;
  logic              parMismatch;
  logic              commitWrite;

  assign memRd = mem[addr_q];

  // A write commits only on the ACCESS edge, and only when reset is not
  // being sampled on that same edge. A reset therefore aborts the write.
  assign commitWrite = reset && (state_q == ACCESS) && !r_wb_q;

  // Next-state logic. The wait counter is loaded from the wait register that
  // is current in IDLE. A same-cycle wait_cfg_en only affects later requests.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (bus_valid) begin
          if (wait_q != 4'd0) begin
            state_d = WAIT;
            wcnt_d  = wait_q;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, request capture, and registered outputs. The outputs are
  // computed from the next state, so each one is valid for the whole cycle
  // in which the FSM sits in the matching state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      wait_q        <= 4'(WAIT_DEF);
      wcnt_q        <= 4'd0;
      addr_q        <= '0;
      wdata_q       <= '0;
      r_wb_q        <= 1'b0;
      parity_inj_q  <= 1'b0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      busy_q        <= (state_d != IDLE);
      rdata_valid_q <= (state_d == RESP) && r_wb_q;
      wr_done_q     <= (state_d == RESP) && !r_wb_q;
      parity_err_q  <= (state_d == RESP) && r_wb_q && parMismatch;
      if (state_q == IDLE) begin
        if (wait_cfg_en) begin
          wait_q <= wait_cfg;
        end
        if (bus_valid) begin
          addr_q       <= addr;
          wdata_q      <= wdata;
          r_wb_q       <= r_wb;
          parity_inj_q <= parity_inj;
        end
      end
      if ((state_q == ACCESS) && r_wb_q) begin
        rdata_q <= memRd;
      end
    end
  end

  // Data array, which has no reset so that contents survive a reset
  always_ff @(posedge clock) begin
    if (commitWrite) begin
      mem[addr_q] <= wdata_q;
    end
  end

`ifdef RAM_PARITY_EN
  logic parMem [0:(1<<ADDR_W)-1];

  // Parity array, written alongside the data and inverted on request
  always_ff @(posedge clock) begin
    if (commitWrite) begin
      parMem[addr_q] <= (^wdata_q) ^ parity_inj_q;
    end
  end

  assign parMismatch = (^memRd) != parMem[addr_q];
`else
  logic unusedParityInj;

  assign parMismatch     = 1'b0;
  assign unusedParityInj = parity_inj_q;
`endif

  assign busy        = busy_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign wr_done     = wr_done_q;
  assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_shared_ram_ctrl.sv
`timescale 1ns/1ps
module tb_shared_ram_ctrl;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 8;
  localparam int WAIT_DEF = 2;

  logic              clock;
  logic              reset;
  logic              bus_valid;
  logic              r_wb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wait_cfg_en;
  logic [3:0]        wait_cfg;
  logic              parity_inj;
  logic              busy;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              wr_done;
  logic              parity_err;

  shared_ram_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WAIT_DEF(WAIT_DEF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus_valid  (bus_valid),
    .r_wb       (r_wb),
    .addr       (addr),
    .wdata      (wdata),
    .wait_cfg_en(wait_cfg_en),
    .wait_cfg   (wait_cfg),
    .parity_inj (parity_inj),
    .busy       (busy),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .wr_done    (wr_done),
    .parity_err (parity_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: the memory as a sparse map, the parity-injection flag
  // of the last write to each word, and the current wait-state setting
  logic [DATA_W-1:0] memModel [int];
  bit                parModel [int];
  int                waitModel;

  typedef struct {
    bit                isRead;
    logic [DATA_W-1:0] data;
    bit                perr;
    int                expCycle;
  } exp_t;

  exp_t              expQ[$];
  exp_t              monExp;
  int                testsRun = 0;
  int                testsFailed = 0;
  logic [DATA_W-1:0] holdRdata;
  bit                checkHold;
  logic [ADDR_W-1:0] pool [0:7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Monitor: pops one expectation per response pulse, catches pulses that
  // arrive late or never, and checks that rdata holds between reads
  always @(negedge clock) begin
    if (reset) begin
      if (rdata_valid || wr_done) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpectedPulse: rdata_valid=%0b wr_done=%0b, expected no pulse (cycle %0d)",
                   rdata_valid, wr_done, cyc);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("respKind", 32'(rdata_valid), 32'(monExp.isRead));
          checkOutput("pulseOverlap", 32'(rdata_valid & wr_done), 32'd0);
          checkOutput("respCycle", 32'(cyc), 32'(monExp.expCycle));
          if (monExp.isRead) begin
            checkOutput("rdata", 32'(rdata), 32'(monExp.data));
            holdRdata = monExp.data;
          end
          checkOutput("parityErr", 32'(parity_err), 32'(monExp.perr));
        end
      end else begin
        if (parity_err) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL strayParity: parity_err=1 without rdata_valid, expected 0 (cycle %0d)", cyc);
        end
        if (checkHold) begin
          checkOutput("rdataHold", 32'(rdata), 32'(holdRdata));
        end
        if (expQ.size() > 0 && cyc > expQ[0].expCycle) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL missingPulse: no response by cycle %0d, expected at cycle %0d", cyc, expQ[0].expCycle);
          void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic waitIdle();
    int guard;
    guard = 0;
    @(negedge clock);
    while (busy && guard < 50) begin
      guard++;
      @(negedge clock);
    end
    if (busy) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL idleTimeout: busy still 1 after %0d cycles, expected 0", guard);
    end
  endtask

  task automatic setWait(input logic [3:0] v);
    waitIdle();
    wait_cfg_en = 1'b1;
    wait_cfg    = v;
    waitModel   = int'(v);
    @(negedge clock);
    wait_cfg_en = 1'b0;
  endtask

  // Issue one request and push its expected response. With noise set, the
  // bus and the config port are scrambled while busy, and the model ignores it.
  task automatic applyStimulus(input bit rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input bit inj, input bit cfgEn, input logic [3:0] cfgVal, input bit noise);
    int   w;
    int   busyCnt;
    exp_t e;
    waitIdle();
    w           = waitModel;
    bus_valid   = 1'b1;
    r_wb        = rd;
    addr        = a;
    wdata       = d;
    parity_inj  = inj;
    wait_cfg_en = cfgEn;
    wait_cfg    = cfgVal;
    if (cfgEn) waitModel = int'(cfgVal);
    e.isRead   = rd;
    e.expCycle = cyc + 2 + w;
    e.data     = '0;
    e.perr     = 1'b0;
    if (rd) begin
      e.data = memModel[int'(a)];
`ifdef RAM_PARITY_EN
      e.perr = parModel[int'(a)];
`endif
    end else begin
      memModel[int'(a)] = d;
      parModel[int'(a)] = inj;
    end
    expQ.push_back(e);
    @(negedge clock);
    bus_valid   = 1'b0;
    wait_cfg_en = 1'b0;
    busyCnt     = 0;
    while (busy && busyCnt < 40) begin
      busyCnt++;
      if (noise) begin
        bus_valid   = 1'($urandom_range(0, 1));
        r_wb        = 1'($urandom_range(0, 1));
        addr        = ADDR_W'($urandom);
        wdata       = DATA_W'($urandom);
        parity_inj  = 1'($urandom_range(0, 1));
        wait_cfg_en = 1'($urandom_range(0, 1));
        wait_cfg    = 4'($urandom);
      end
      @(negedge clock);
    end
    bus_valid   = 1'b0;
    wait_cfg_en = 1'b0;
    checkOutput("busyCycles", 32'(busyCnt), 32'(2 + w));
  endtask

  // Start a write, then pull reset lag cycles after the request was sampled.
  // The write must leave no trace in memory and produce no pulse.
  task automatic abortWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int lag);
    waitIdle();
    bus_valid  = 1'b1;
    r_wb       = 1'b0;
    addr       = a;
    wdata      = d;
    parity_inj = 1'b0;
    @(negedge clock);
    bus_valid = 1'b0;
    repeat (lag - 1) @(negedge clock);
    checkOutput("busyBeforeAbort", 32'(busy), 32'd1);
    reset     = 1'b0;
    checkHold = 1'b0;
    holdRdata = '0;
    @(negedge clock);
    checkOutput("busyAfterAbort", 32'(busy), 32'd0);
    checkOutput("rdataAfterAbort", 32'(rdata), 32'd0);
    reset     = 1'b1;
    waitModel = WAIT_DEF;
    @(negedge clock);
    checkHold = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    bus_valid   = 1'b0;
    r_wb        = 1'b0;
    addr        = '0;
    wdata       = '0;
    wait_cfg_en = 1'b0;
    wait_cfg    = 4'd0;
    parity_inj  = 1'b0;
    waitModel   = WAIT_DEF;
    holdRdata   = '0;
    checkHold   = 1'b0;
    pool[0] = 12'h000; pool[1] = 12'hFFF; pool[2] = 12'h123; pool[3] = 12'h055;
    pool[4] = 12'h800; pool[5] = 12'h7FF; pool[6] = 12'h001; pool[7] = 12'hABC;

    repeat (3) @(negedge clock);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetRdata", 32'(rdata), 32'd0);
    checkOutput("resetRdataValid", 32'(rdata_valid), 32'd0);
    checkOutput("resetWrDone", 32'(wr_done), 32'd0);
    checkOutput("resetParityErr", 32'(parity_err), 32'd0);
    reset     = 1'b1;
    checkHold = 1'b1;

    // Basic write then read with the default wait count, plus address extremes
    applyStimulus(1'b0, 12'h123, 8'hA5, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 12'h123, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 12'h000, 8'h5A, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 12'hFFF, 8'h11, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 12'hFFF, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);

    // Wait count extremes: zero and seven, then the maximum of fifteen
    setWait(4'd0);
    applyStimulus(1'b1, 12'h123, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    setWait(4'd7);
    applyStimulus(1'b1, 12'hFFF, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    setWait(4'd15);
    applyStimulus(1'b0, 12'h7FF, 8'hC3, 1'b0, 1'b0, 4'd0, 1'b0);

    // Bus activity while busy is ignored
    setWait(4'd1);
    applyStimulus(1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
    applyStimulus(1'b0, 12'h000, 8'h77, 1'b0, 1'b0, 4'd0, 1'b1);
    applyStimulus(1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);

    // Reset in WAIT and in ACCESS aborts the write
    setWait(4'd5);
    abortWrite(12'hFFF, 8'h3C, 2);
    applyStimulus(1'b1, 12'hFFF, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    setWait(4'd0);
    abortWrite(12'h123, 8'hEE, 1);
    applyStimulus(1'b1, 12'h123, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);

    // Config and request in the same idle cycle: old count now, new count next
    setWait(4'd2);
    applyStimulus(1'b1, 12'h123, 8'h00, 1'b0, 1'b1, 4'd4, 1'b0);
    applyStimulus(1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);

    // Parity injection and a clean write at the same word
    setWait(4'd1);
    applyStimulus(1'b0, 12'h055, 8'h01, 1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 12'h055, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 12'h055, 8'h01, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 12'h055, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [ADDR_W-1:0] a;
      bit                rd;
      bit                cfg;
      logic [3:0]        cv;
      a   = pool[$urandom_range(0, 7)];
      rd  = 1'($urandom_range(0, 1));
      if (!memModel.exists(int'(a))) rd = 1'b0;
      cfg = ($urandom_range(0, 4) == 0);
      cv  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      applyStimulus(rd, a, DATA_W'($urandom), 1'($urandom_range(0, 1)), cfg, cv,
                    1'($urandom_range(0, 1)));
    end

    repeat (30) @(negedge clock);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
